// File: rtl/tone_pkg.sv
// Shared constants for the tone organ note sequencer: note divider table,
// auto-sequencer state encoding and the reset divider value.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_DIV = 32'd47801;
  localparam logic [2:0]  LAST_NOTE   = 3'd7;

  // Half-period counts for a 50 MHz clock, Do (index 0) up to Do' (index 7)
  localparam logic [31:0] NOTE_DIV [0:7] = '{
    32'd47801, 32'd42589, 32'd37936, 32'd35816,
    32'd31928, 32'd28409, 32'd25329, 32'd23900
  };

  function automatic logic [31:0] note_div(input logic [2:0] idx);
    return NOTE_DIV[idx];
  endfunction

endpackage

// File: rtl/tone_note_sequencer_if.sv
// Control/status bundle between the organ front panel (master) and the
// note sequencer (slave).
interface tone_note_sequencer_if;

  logic [2:0]  sw_note;
  logic        auto_mode;
  logic        start;
  logic        stop;
  logic        loop;
  logic [31:0] div_clk_count;
  logic        tone_en;
  logic [2:0]  note_idx;
  logic        busy;
  logic        note_strobe;

  modport master (
    output sw_note, auto_mode, start, stop, loop,
    input  div_clk_count, tone_en, note_idx, busy, note_strobe
  );

  modport slave (
    input  sw_note, auto_mode, start, stop, loop,
    output div_clk_count, tone_en, note_idx, busy, note_strobe
  );

endinterface

// File: rtl/tone_note_rom.sv
// Note index to clock-divider half-period count lookup (combinational).
module tone_note_rom
  import tone_pkg::*;
(
  input  logic [2:0]  idx_i,
  output logic [31:0] count_o
);

  assign count_o = note_div(idx_i);

endmodule

// File: rtl/tone_note_sequencer.sv
// Tone organ control stage: manual note select or timed auto playback of the
// Do..Do' scale, driving the divider half-period count and the tone gate.
module tone_note_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic                  inclk,
  input  logic                  Reset,
  tone_note_sequencer_if.slave  bus
);

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic [31:0] div_q;
  logic        tone_q;
  logic [2:0]  idx_q;
  logic        busy_q;
  logic        strobe_q;

  logic [2:0]  rom_idx_s;
  logic [31:0] rom_count_s;

  // Single ROM shared by both paths: manual takes the switches, auto takes
  // the note about to start (0 from IDLE, idx+1 from GAP, wrapping 7->0).
  always_comb begin
    timer_d   = timer_q + 32'd1;
    rom_idx_s = bus.sw_note;
    if (!bus.auto_mode) begin
      rom_idx_s = bus.sw_note;
    end else if (state_q == ST_IDLE) begin
      rom_idx_s = 3'd0;
    end else begin
      rom_idx_s = idx_q + 3'd1;
    end
  end

  tone_note_rom u_rom (
    .idx_i   (rom_idx_s),
    .count_o (rom_count_s)
  );

  // Auto-play FSM, note timer and all registered outputs
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= 32'd0;
      div_q    <= DEFAULT_DIV;
      tone_q   <= 1'b0;
      idx_q    <= 3'd0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else if (!bus.auto_mode) begin
      state_q  <= ST_IDLE;
      timer_q  <= 32'd0;
      div_q    <= rom_count_s;
      idx_q    <= bus.sw_note;
      tone_q   <= 1'b1;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tone_q  <= 1'b0;
          busy_q  <= 1'b0;
          timer_q <= 32'd0;
          if (bus.start && !bus.stop) begin
            state_q  <= ST_PLAY;
            busy_q   <= 1'b1;
            idx_q    <= rom_idx_s;
            div_q    <= rom_count_s;
            tone_q   <= 1'b1;
            strobe_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
            timer_q <= 32'd0;
          end else if (timer_q == NOTE_LAST) begin
            state_q <= ST_GAP;
            tone_q  <= 1'b0;
            timer_q <= 32'd0;
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_GAP: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
            timer_q <= 32'd0;
          end else if (timer_q == GAP_LAST) begin
            timer_q <= 32'd0;
            // Loop is only consulted at the end of the final note's gap
            if ((idx_q != LAST_NOTE) || bus.loop) begin
              state_q  <= ST_PLAY;
              idx_q    <= rom_idx_s;
              div_q    <= rom_count_s;
              tone_q   <= 1'b1;
              strobe_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tone_q  <= 1'b0;
          timer_q <= 32'd0;
        end
      endcase
    end
  end

  assign bus.div_clk_count = div_q;
  assign bus.tone_en       = tone_q;
  assign bus.note_idx      = idx_q;
  assign bus.busy          = busy_q;
  assign bus.note_strobe   = strobe_q;

endmodule

// File: tb/tb_tone_note_sequencer.sv
// Scoreboard bench for tone_note_sequencer: directed scenarios plus random
// stimulus, expected outputs from a schedule-based playback model.
module tb_tone_note_sequencer;

  localparam int NC = 4;
  localparam int GC = 2;
  localparam int P  = NC + GC;

  logic inclk = 1'b0;
  logic Reset = 1'b0;

  tone_note_sequencer_if bus ();

  tone_note_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
    .inclk (inclk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 inclk = ~inclk;

  typedef struct packed {
    logic [31:0] div;
    logic        tone;
    logic [2:0]  idx;
    logic        busy;
    logic        strobe;
  } exp_t;

  localparam logic [31:0] TABLE [0:7] = '{
    32'd47801, 32'd42589, 32'd37936, 32'd35816,
    32'd31928, 32'd28409, 32'd25329, 32'd23900
  };

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int busy_cnt = 0;

  // Playback model: an active run is described only by the cycle it began on;
  // the note and its phase follow from elapsed time by division.
  logic [31:0] m_div = 32'd47801;
  logic [2:0]  m_idx = 3'd0;
  bit          m_active = 1'b0;
  longint      m_cyc = 0;
  longint      m_base = 0;

  task automatic model_step(input logic rst_lvl, input logic [2:0] sw, input logic am,
                            input logic st, input logic sp, input logic lp, output exp_t e);
    longint el;
    int n, ph;
    el = 0;
    e.strobe = 1'b0;
    e.busy   = 1'b0;
    e.tone   = 1'b0;
    if (!rst_lvl) begin
      m_active = 1'b0;
      m_div    = 32'd47801;
      m_idx    = 3'd0;
    end else if (!am) begin
      m_active = 1'b0;
      m_div    = TABLE[sw];
      m_idx    = sw;
      e.tone   = 1'b1;
    end else begin
      if (m_active && sp) m_active = 1'b0;
      else if (!m_active && st && !sp) begin
        m_active = 1'b1;
        m_base   = m_cyc;
      end
      if (m_active) begin
        el = m_cyc - m_base;
        if (el >= 8 * P) begin
          if (lp) begin
            m_base = m_cyc;
            el = 0;
          end else m_active = 1'b0;
        end
      end
      if (m_active) begin
        n = int'(el / P);
        ph = int'(el % P);
        m_idx    = n[2:0];
        m_div    = TABLE[n];
        e.tone   = (ph < NC);
        e.strobe = (ph == 0);
        e.busy   = 1'b1;
      end
    end
    e.div = m_div;
    e.idx = m_idx;
    m_cyc++;
  endtask

  // Called at negedge+1: drive inputs for the coming posedge and queue its result
  task automatic drive(input logic [2:0] sw, input logic am, input logic st,
                       input logic sp, input logic lp);
    exp_t e;
    bus.sw_note   = sw;
    bus.auto_mode = am;
    bus.start     = st;
    bus.stop      = sp;
    bus.loop      = lp;
    model_step(Reset, sw, am, st, sp, lp, e);
    exp_q.push_back(e);
    @(negedge inclk);
    #1;
  endtask

  task automatic idle(input int n, input logic am, input logic lp);
    for (int i = 0; i < n; i++) drive(3'($urandom_range(7, 0)), am, 1'b0, 1'b0, lp);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic async_reset(input int hold);
    Reset = 1'b0;
    #1;
    check("reset_tone_en", {31'd0, bus.tone_en}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_div", bus.div_clk_count, 32'd47801);
    check("reset_note_idx", {29'd0, bus.note_idx}, 32'd0);
    check("reset_strobe", {31'd0, bus.note_strobe}, 32'd0);
    for (int i = 0; i < hold; i++) drive(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
  endtask

  // Monitor: every sampled output cycle is compared against the queued prediction
  always @(negedge inclk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.div_clk_count, bus.tone_en, bus.note_idx, bus.busy, bus.note_strobe};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: actual div=%0d tone=%0b idx=%0d busy=%0b strobe=%0b, required div=%0d tone=%0b idx=%0d busy=%0b strobe=%0b",
                 $time, a.div, a.tone, a.idx, a.busy, a.strobe,
                 e.div, e.tone, e.idx, e.busy, e.strobe);
      end
      if (bus.note_strobe) strobe_cnt++;
      if (bus.busy) busy_cnt++;
    end
  end

  initial begin
    bus.sw_note = 3'd0;
    bus.auto_mode = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    @(negedge inclk);
    #1;
    idle(3, 1'b1, 1'b0);
    Reset = 1'b1;
    idle(3, 1'b1, 1'b0);

    // Manual select with one-cycle latency
    drive(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full scale, no loop: 8 strobes, 48 busy cycles
    idle(2, 1'b1, 1'b0);
    strobe_cnt = 0;
    busy_cnt = 0;
    drive(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(54, 1'b1, 1'b0);
    check("scale_strobes", 32'(strobe_cnt), 32'd8);
    check("scale_busy_span", 32'(busy_cnt), 32'd48);

    // Looping playback wraps to note 0, then stop during note 2
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(48 + 13, 1'b1, 1'b1);
    drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);

    // start+stop together stays idle; start while busy is ignored
    drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(25, 1'b1, 1'b0);
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(30, 1'b1, 1'b0);

    // Drop to manual during note 1's gap
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1, 1'b0);
    drive(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);

    // Asynchronous reset while note 3 is playing
    drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(19, 1'b1, 1'b0);
    async_reset(2);
    idle(5, 1'b1, 1'b0);

    // Randomized traffic
    begin
      logic am;
      am = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(199, 0) == 0) am = ~am;
        if ($urandom_range(499, 0) == 0) async_reset(1);
        else drive(3'($urandom_range(7, 0)), am,
                   ($urandom_range(14, 0) == 0), ($urandom_range(79, 0) == 0),
                   1'($urandom_range(1, 0)));
      end
    end

    @(negedge inclk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
